// File: rtl/des_pkg.sv
// DES permutation tables, S-boxes and bit-permutation helpers shared by the
// encryption core. Bit numbering follows DES: bit 1 is the MSB of each vector.
package des_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int UNROLL = 4;
  localparam int KEY_BLK_W = 48 * UNROLL;

  localparam int IP_TBL [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int FP_TBL [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25
  };

  localparam int E_TBL [48] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1
  };

  localparam int P_TBL [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25
  };

  // Each S-box row-major: index = {row, col} with row = outer bits, col = middle bits.
  localparam int SBOX [8][64] = '{
    '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
       0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
       4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
      15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
    '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
       3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
       0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
      13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
    '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
      13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
       1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
    '{ 7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
      13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
      10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
       3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
    '{ 2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
      14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
       4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
      11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
    '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
      10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
       9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
       4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
    '{ 4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
      13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
       1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
       6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
    '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
       1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
       7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
       2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}
  };

  function automatic logic [63:0] des_ip(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_TBL[i]];
    return y;
  endfunction

  function automatic logic [63:0] des_fp(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_TBL[i]];
    return y;
  endfunction

  function automatic logic [47:0] des_e(input logic [31:0] x);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[47-i] = x[32-E_TBL[i]];
    return y;
  endfunction

  function automatic logic [31:0] des_p(input logic [31:0] x);
    logic [31:0] y;
    y = '0;
    for (int i = 0; i < 32; i++) y[31-i] = x[32-P_TBL[i]];
    return y;
  endfunction

  function automatic logic [3:0] des_sbox(input int n, input logic [5:0] b);
    return 4'(SBOX[n][{b[5], b[0], b[4:1]}]);
  endfunction

endpackage

// File: rtl/des_round.sv
// One combinational DES Feistel round: L' = R, R' = L xor f(R, K).
module des_round
  import des_pkg::*;
(
  input  logic [31:0] l,
  input  logic [31:0] r,
  input  logic [47:0] k,
  output logic [31:0] l_next,
  output logic [31:0] r_next
);

  logic [47:0] x;
  logic [31:0] s;

  always_comb begin
    x = des_e(r) ^ k;
    s = '0;
    for (int i = 0; i < 8; i++) s[31-4*i -: 4] = des_sbox(i, x[47-6*i -: 6]);
  end

  assign l_next = r;
  assign r_next = l ^ des_p(s);

endmodule

// File: rtl/des_encryption_unroll4.sv
// Iterative DES encryption core: four chained Feistel rounds per clock, so a
// block completes in four BUSY cycles using precomputed round keys.
module des_encryption_unroll4
  import des_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [63:0]  message,
  input  logic [767:0] round_keys,
  output logic         done,
  output logic [63:0]  result,
  output logic         state_dbg
);

  // Handshake: start is a one-cycle pulse honoured only in IDLE (message is
  // sampled on that edge, round_keys must stay stable until done); done is a
  // one-cycle pulse qualifying result, which then holds until the next done.
  state_t                    state;
  logic [1:0]                cnt;
  logic [31:0]               l_q, r_q;
  logic [KEY_BLK_W-1:0]      key_blk;
  logic [UNROLL:0][31:0]     l_c, r_c;

  always_comb begin
    case (cnt)
      2'd0:    key_blk = round_keys[767:576];
      2'd1:    key_blk = round_keys[575:384];
      2'd2:    key_blk = round_keys[383:192];
      default: key_blk = round_keys[191:0];
    endcase
  end

  assign l_c[0] = l_q;
  assign r_c[0] = r_q;

  for (genvar g = 0; g < UNROLL; g++) begin : g_round
    des_round u_round (
      .l      (l_c[g]),
      .r      (r_c[g]),
      .k      (key_blk[KEY_BLK_W-1-48*g -: 48]),
      .l_next (l_c[g+1]),
      .r_next (r_c[g+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 2'd0;
      l_q    <= '0;
      r_q    <= '0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            {l_q, r_q} <= des_ip(message);
            cnt        <= 2'd0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          l_q <= l_c[UNROLL];
          r_q <= r_c[UNROLL];
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            // Round 16 output is un-swapped before the final permutation.
            result <= des_fp({r_c[UNROLL], l_c[UNROLL]});
            done   <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign state_dbg = (state == BUSY);

endmodule

// File: tb/tb_des_encryption_unroll4.sv
// Bench for des_encryption_unroll4: known-answer vectors, handshake corner
// cases and randomized blocks checked against a behavioural DES model.
module tb_des_encryption_unroll4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [63:0]  message;
  logic [767:0] round_keys;
  logic         done;
  logic [63:0]  result;
  logic         state_dbg;

  int test_cnt = 0;
  int fail_cnt = 0;
  int done_cnt = 0;
  int d0;
  int lat;
  logic [63:0]  exp_q[$];
  logic [63:0]  held_exp = '0;
  logic [767:0] rk_a, rk_b, rk_r;
  logic [63:0]  msg_r;

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7
  };
  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25
  };
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32
  };
  localparam int SH_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam int SB [512] = '{
    14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
    0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
    4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
    15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13,
    15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
    3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
    0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
    13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9,
    10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
    13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
    13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
    1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12,
    7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
    13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
    10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
    3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14,
    2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
    14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
    4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
    11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3,
    12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
    10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
    9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
    4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13,
    4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
    13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
    1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
    6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12,
    13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
    1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
    7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
    2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11
  };

  des_encryption_unroll4 dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .message    (message),
    .round_keys (round_keys),
    .done       (done),
    .result     (result),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // E is built from its rule (each 6-bit group wraps around a 4-bit nibble).
  function automatic logic [31:0] model_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e;
    logic [31:0] s, p;
    int src, six, row, col;
    for (int g = 0; g < 8; g++)
      for (int j = 0; j < 6; j++) begin
        src = (4 * g + j + 31) % 32 + 1;
        e[47 - (6 * g + j)] = r[32 - src];
      end
    e = e ^ k;
    for (int g = 0; g < 8; g++) begin
      six = int'((e >> (42 - 6 * g)) & 48'h3f);
      row = ((six >> 5) & 1) * 2 + (six & 1);
      col = (six >> 1) & 15;
      s[31 - 4 * g -: 4] = 4'(SB[g * 64 + row * 16 + col]);
    end
    for (int i = 0; i < 32; i++) p[31 - i] = s[32 - P_T[i]];
    return p;
  endfunction

  // FP is applied as the inverse of IP.
  function automatic logic [63:0] model_encrypt(input logic [63:0] msg, input logic [767:0] rk);
    logic [63:0] t, o;
    logic [31:0] l, r, tmp;
    for (int i = 0; i < 64; i++) t[63 - i] = msg[64 - IP_T[i]];
    l = t[63:32];
    r = t[31:0];
    for (int n = 0; n < 16; n++) begin
      tmp = r;
      r   = l ^ model_f(r, rk[767 - 48 * n -: 48]);
      l   = tmp;
    end
    t = {r, l};
    for (int i = 0; i < 64; i++) o[64 - IP_T[i]] = t[63 - i];
    return o;
  endfunction

  function automatic logic [767:0] model_keys(input logic [63:0] key);
    logic [55:0]  cd;
    logic [27:0]  c, d;
    logic [47:0]  kn;
    logic [767:0] rk;
    for (int i = 0; i < 56; i++) cd[55 - i] = key[64 - PC1_T[i]];
    c  = cd[55:28];
    d  = cd[27:0];
    rk = '0;
    for (int n = 0; n < 16; n++) begin
      for (int s = 0; s < SH_T[n]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) kn[47 - i] = cd[56 - PC2_T[i]];
      rk[767 - 48 * n -: 48] = kn;
    end
    return rk;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    test_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse must consume one expected result.
  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      done_cnt++;
      check("done_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        held_exp = exp_q.pop_front();
        check("result", result, held_exp);
      end
    end
  end

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic start_op(input logic [63:0] msg, input logic [767:0] rk);
    message    = msg;
    round_keys = rk;
    start      = 1'b1;
    exp_q.push_back(model_encrypt(msg, rk));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int lat0, input string tag);
    lat = lat0;
    while (done !== 1'b1 && lat < 12) begin
      check({tag, "_hold"}, result, held_exp);
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd4);
  endtask

  task automatic run_enc(input logic [63:0] msg, input logic [767:0] rk, input string tag);
    start_op(msg, rk);
    wait_done(0, tag);
  endtask

  task automatic directed(input logic [63:0] key, input logic [63:0] msg,
                          input logic [63:0] kat, input string tag);
    rk_a = model_keys(key);
    @(negedge clk);
    d0 = done_cnt;
    run_enc(msg, rk_a, tag);
    check({tag, "_kat"}, result, kat);
    @(negedge clk);
    check({tag, "_pulse"}, 64'(done), 64'd0);
    check({tag, "_count"}, 64'(done_cnt - d0), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    message    = '0;
    round_keys = '0;
    repeat (3) @(negedge clk);
    check("reset_done", 64'(done), 64'd0);
    check("reset_result", result, 64'd0);
    check("reset_state", 64'(state_dbg), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Known-answer vectors, including key schedule anchors.
    rk_a = model_keys(64'h133457799BBCDFF1);
    check("ks_k1", 64'(rk_a[767:720]), 64'h1B02EFFC7072);
    check("ks_k16", 64'(rk_a[47:0]), 64'hCB3D8B0E17F5);
    directed(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 64'h85E813540F0AB405, "kat1");
    directed(64'h0000000000000000, 64'h0000000000000000, 64'h8CA64DE9C1B123A7, "kat_zero");
    directed(64'h0123456789ABCDEF, 64'h4E6F772069732074, 64'h3FA40E8A984D4815, "kat_now");

    // Back-to-back: second start lands in the done cycle of the first.
    rk_a = model_keys(64'h0E329232EA6D0D73);
    rk_b = model_keys(64'h133457799BBCDFF1);
    @(negedge clk);
    run_enc(64'h8787878787878787, rk_a, "b2b_first");
    check("b2b_first_kat", result, 64'h0000000000000000);
    run_enc(64'hFEDCBA9876543210, rk_b, "b2b_second");

    // start while BUSY must be ignored.
    @(negedge clk);
    d0 = done_cnt;
    start_op(64'h0123456789ABCDEF, model_keys(64'h133457799BBCDFF1));
    @(negedge clk);
    message = 64'hDEADBEEFCAFEF00D;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2, "busy_start");
    check("busy_start_kat", result, 64'h85E813540F0AB405);
    repeat (6) @(negedge clk);
    check("busy_start_count", 64'(done_cnt - d0), 64'd1);
    check("busy_start_held", result, 64'h85E813540F0AB405);

    // Reset mid-operation abandons the block and clears result.
    start_op(64'h4E6F772069732074, model_keys(64'h0123456789ABCDEF));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    held_exp = '0;
    d0 = done_cnt;
    check("rst_state", 64'(state_dbg), 64'd0);
    repeat (6) begin
      check("rst_done", 64'(done), 64'd0);
      check("rst_result", result, 64'd0);
      @(negedge clk);
    end
    check("rst_no_done", 64'(done_cnt - d0), 64'd0);
    directed(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 64'h85E813540F0AB405, "after_rst");

    // Randomized blocks, schedule-derived or arbitrary key buses.
    for (int t = 0; t < 12; t++) begin
      if ($urandom_range(0, 1) == 1) rk_r = model_keys({$urandom, $urandom});
      else for (int w = 0; w < 24; w++) rk_r[w * 32 +: 32] = $urandom;
      msg_r = {$urandom, $urandom};
      if ($urandom_range(0, 2) != 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      run_enc(msg_r, rk_r, "rand");
    end

    repeat (4) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
